map_port_arbiter: RTL and testbench
===================================

# map_port_arbiter

Shares the single tile-map RAM port among several map clients: Pac-Man movement, ghost AI, pellet clearing and the tile renderer. Each requester issues read or write tile accesses with a req/gnt handshake. The block grants one access per cycle, drives the RAM port and routes read data back to the granting requester after the RAM latency. It sits between the game-logic blocks and the map RAM and replaces direct array reads of the map.

## Interface
Parameters:
- N_REQ, 4: number of requesters; index 0 is the renderer.
- RAM_LATENCY, 1: cycles from ram_en to valid ram_rdata; legal range 1..3.

Ports:
- vga_pix_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  access request per requester; held until granted.
- we  in  N_REQ  1 = write, 0 = read; qualified by req.
- addr  in  N_REQ x MAP_ADDR_W  tile index, x + y*32.
- wdata  in  N_REQ x TILE_W  write tile value.
- gnt  out  N_REQ  one-hot grant, combinational from req and state.
- rvalid  out  N_REQ  one-hot read-data-valid.
- rdata  out  TILE_W  read data, shared; qualified by rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  MAP_ADDR_W  RAM address.
- ram_wdata  out  TILE_W  RAM write data.
- ram_rdata  in  TILE_W  RAM read data, RAM_LATENCY cycles after ram_en.

## Operation
- Each cycle, at most one gnt bit is high, and only for a requester with req=1.
- gnt[i]=1 means the access is taken that cycle. The requester may change req, addr, we or wdata on the next cycle.
- Round-robin selection: the search starts at index ptr and wraps modulo N_REQ. The first requester found wins.
- On a grant to index i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- In-range access (addr < MAP_TILES): ram_en=1, and ram_we, ram_addr and ram_wdata are taken from the winner in the same cycle.
- Out-of-range access (addr >= MAP_TILES):
  - The access is still granted, but ram_en=0.
  - A read returns TILE_WALL, so off-map looks solid.
  - A write is dropped.
- Writes never produce rvalid.
- Read return pipeline: a shift register RAM_LATENCY deep, carrying {one-hot id, oob flag}.
  - At the output stage, rvalid = id.
  - rdata = oob ? TILE_WALL : ram_rdata.
- When rvalid is all zeros, rdata is don't-care; it is driven to 0.
- Unused ram_addr and ram_wdata are driven to 0 when ram_en=0.

## Timing
- Grant latency: 0 cycles. gnt and the RAM port are combinational on the cycle req is seen, given ptr.
- Read latency: rvalid[i] is high exactly RAM_LATENCY cycles after gnt[i], for 1 cycle per grant.
- Throughput: 1 access per cycle. Back-to-back reads from different requesters return in grant order.
- Worst-case wait with all requesters saturating: N_REQ-1 cycles.
- Reset values: ptr=0, return pipeline empty, rvalid=0, rdata=0.
- Outputs under reset:
  - gnt=0 while rst is high, regardless of req.
  - ram_en=0 and ram_we=0 while rst is high.
- Reset mid-operation: in-flight reads are discarded asynchronously and no rvalid appears afterwards. Requesters must re-issue.
- A requester dropping req before its grant is a protocol violation. The bench asserts that req stays high until gnt.

## Configuration
- MAP_ARB_RENDER_PRIO_EN
  - Defined: requester 0 (renderer) wins whenever req[0]=1, regardless of ptr. Round-robin applies only among 1..N_REQ-1. ptr is not updated on a requester-0 grant.
  - Undefined: pure round-robin over all N_REQ requesters, as described above.

## Structure
- Shared package params gains:
  - MAP_W=32, MAP_H=36, MAP_TILES=MAP_W*MAP_H (1152).
  - MAP_ADDR_W=$clog2(MAP_TILES) (11).
  - TILE_W=4, TILE_WALL=4'hF.
- One sub-module, rr_pick: combinational round-robin picker with N_REQ req bits in, ptr in, one-hot gnt out and winner index out. It is reused for the 1..N_REQ-1 subset when MAP_ARB_RENDER_PRIO_EN is defined.
- The return pipeline and ptr register live in map_port_arbiter.

## Test plan
- Single read: req[1]=1, addr=35, RAM holds 2 at 35, RAM_LATENCY=1 -> gnt[1] same cycle; next cycle rvalid=4'b0010, rdata=2.
- All four requesters reading continuously from reset -> grants cycle 0,1,2,3,0,…; each rvalid follows its grant by RAM_LATENCY; no requester waits more than 3 cycles.
- Write then read: req[2] we=1 addr=100 wdata=0, then read addr=100 -> ram_we pulse on cycle 0; read returns 0; no rvalid for the write.
- Out-of-range: read addr=1152 -> gnt, ram_en=0, rvalid later with rdata=4'hF; write addr=2047 -> gnt, RAM unchanged.
- Reset mid-flight: grant a read with RAM_LATENCY=3 and assert rst 1 cycle later -> rvalid never asserts; ptr=0 after release; gnt=0 throughout reset.
- MAP_ARB_RENDER_PRIO_EN defined, req=4'b1111 held -> gnt[0] every cycle, others starved. Undefined: rotation as in the all-requesters scenario.

Source files
------------

// File: rtl/map_port_arbiter_pkg.sv
// map_port_arbiter_pkg: tile-map geometry, tile encoding and address helpers
// shared by the map RAM arbiter and its round-robin picker.
package map_port_arbiter_pkg;

   localparam int MAP_W      = 32;
   localparam int MAP_H      = 36;
   localparam int MAP_TILES  = MAP_W * MAP_H;
   localparam int MAP_ADDR_W = $clog2(MAP_TILES);

   localparam int                TILE_W    = 4;
   localparam logic [TILE_W-1:0] TILE_WALL = 4'hF;

   // True when a tile index lies inside the playfield (x + y*32 < 1152).
   function automatic logic addr_on_map(input logic [MAP_ADDR_W-1:0] a);
      return a < MAP_ADDR_W'(MAP_TILES);
   endfunction

endpackage

// File: rtl/map_port_arbiter_rr_pick.sv
// map_port_arbiter_rr_pick: combinational round-robin picker. Scans i_req
// starting at i_ptr, wrapping modulo N, and returns the first active request
// as a one-hot grant plus its index.
module map_port_arbiter_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx
);

   int   w_cand;
   logic w_found;

   // Walk the requesters from the pointer upward and keep the first hit
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a
      // value unassigned, which would otherwise infer a latch.
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int k = 0; k < N; k++) begin
         w_cand = (int'(i_ptr) + k) % N;
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = IDX_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the single tile-map RAM port among the map clients
// (renderer at index 0, then Pac-Man, ghost AI, pellet clearing). One access is
// granted per cycle with zero latency; read data returns to the granted client
// RAM_LATENCY cycles later. Off-map reads return TILE_WALL, off-map writes are
// dropped.
// Build option: define MAP_ARB_RENDER_PRIO_EN to give requester 0 absolute
// priority, with round-robin among the remaining requesters only.
module map_port_arbiter
   import map_port_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int RAM_LATENCY = 1
) (
   input  logic                               vga_pix_clk,
   input  logic                               rst,
   input  logic [N_REQ-1:0]                   req,
   input  logic [N_REQ-1:0]                   we,
   input  logic [N_REQ-1:0][MAP_ADDR_W-1:0]   addr,
   input  logic [N_REQ-1:0][TILE_W-1:0]       wdata,
   output logic [N_REQ-1:0]                   gnt,
   output logic [N_REQ-1:0]                   rvalid,
   output logic [TILE_W-1:0]                  rdata,
   output logic                               ram_en,
   output logic                               ram_we,
   output logic [MAP_ADDR_W-1:0]              ram_addr,
   output logic [TILE_W-1:0]                  ram_wdata,
   input  logic [TILE_W-1:0]                  ram_rdata
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // One return-pipeline slot: who gets the data, and whether it is off-map.
   typedef struct packed {
      logic [N_REQ-1:0] id;
      logic             oob;
   } ret_t;

   logic [PTR_W-1:0]       r_ptr;
   ret_t [RAM_LATENCY-1:0] r_ret;

   logic [N_REQ-1:0]      w_rr_req;
   logic [N_REQ-1:0]      w_rr_gnt;
   logic [N_REQ-1:0]      w_pick_gnt;
   logic [PTR_W-1:0]      w_rr_idx;
   logic [PTR_W-1:0]      w_win_idx;
   logic                  w_ptr_adv;
   logic                  w_any;
   logic                  w_sel_we;
   logic                  w_on_map;
   logic [MAP_ADDR_W-1:0] w_sel_addr;
   logic [TILE_W-1:0]     w_sel_wdata;
   ret_t                  w_ret_in;
   ret_t                  w_ret_out;

   map_port_arbiter_rr_pick #(
      .N     (N_REQ),
      .IDX_W (PTR_W)
   ) u_rr_pick (
      .i_req (w_rr_req),
      .i_ptr (r_ptr),
      .o_gnt (w_rr_gnt),
      .o_idx (w_rr_idx)
   );

   // Choose the winner: round-robin pick, optionally overridden by the renderer
   always_comb begin
`ifdef MAP_ARB_RENDER_PRIO_EN
      w_rr_req   = req & ~N_REQ'(1);
      w_pick_gnt = req[0] ? N_REQ'(1) : w_rr_gnt;
      w_win_idx  = req[0] ? '0 : w_rr_idx;
      w_ptr_adv  = ~req[0] & (|w_rr_gnt);
`else
      w_rr_req   = req;
      w_pick_gnt = w_rr_gnt;
      w_win_idx  = w_rr_idx;
      w_ptr_adv  = |w_rr_gnt;
`endif
   end

   // Nothing is granted while reset is held, whatever the requesters do.
   assign gnt   = rst ? '0 : w_pick_gnt;
   assign w_any = |gnt;

   assign w_sel_addr  = addr[w_win_idx];
   assign w_sel_we    = we[w_win_idx];
   assign w_sel_wdata = wdata[w_win_idx];
   assign w_on_map    = addr_on_map(w_sel_addr);

   // Drive the RAM port from the winner and build the return-pipeline entry
   always_comb begin
      ram_en    = w_any & w_on_map;
      ram_we    = ram_en & w_sel_we;
      ram_addr  = ram_en ? w_sel_addr : '0;
      ram_wdata = ram_en ? w_sel_wdata : '0;
      w_ret_in  = '0;
      if (w_any && !w_sel_we) begin
         w_ret_in.id  = gnt;
         w_ret_in.oob = ~w_on_map;
      end
   end

   // Advance the round-robin pointer past each round-robin winner
   always_ff @(posedge vga_pix_clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_ptr <= '0;
      end else if (w_ptr_adv) begin
         r_ptr <= PTR_W'((int'(w_win_idx) + 1) % N_REQ);
      end
   end

   // Shift read tags alongside the RAM latency
   always_ff @(posedge vga_pix_clk or posedge rst) begin
      // NOTE: this pipeline is a handful of flops, not a memory, and it must be
      // cleared asynchronously so in-flight reads never surface after reset.
      if (rst) begin
         r_ret <= '0;
      end else begin
         r_ret[0] <= w_ret_in;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            r_ret[s] <= r_ret[s-1];
         end
      end
   end

   assign w_ret_out = r_ret[RAM_LATENCY-1];

   // Present returned data to its owner; off-map reads look like solid wall
   always_comb begin
      rvalid = w_ret_out.id;
      rdata  = '0;
      if (|w_ret_out.id) begin
         rdata = w_ret_out.oob ? TILE_WALL : ram_rdata;
      end
   end

endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: directed tests for map_port_arbiter. Two instances share
// the same requester stimulus: one with RAM_LATENCY=1, one with RAM_LATENCY=3,
// each backed by a behavioural map RAM model of matching latency.
module tb_map_port_arbiter;

   logic              vga_pix_clk;
   logic              rst;
   logic [3:0]        req;
   logic [3:0]        we;
   logic [3:0][10:0]  addr;
   logic [3:0][3:0]   wdata;

   logic [3:0]  gnt,  rvalid;
   logic [3:0]  rdata;
   logic        ram_en, ram_we;
   logic [10:0] ram_addr;
   logic [3:0]  ram_wdata, ram_rdata;

   logic [3:0]  gnt3, rvalid3;
   logic [3:0]  rdata3;
   logic        ram_en3, ram_we3;
   logic [10:0] ram_addr3;
   logic [3:0]  ram_wdata3, ram_rdata3;

   int n_checks;
   int n_errors;
   logic proto_en;

   map_port_arbiter #(.N_REQ(4), .RAM_LATENCY(1)) u_dut (
      .vga_pix_clk (vga_pix_clk), .rst (rst), .req (req), .we (we),
      .addr (addr), .wdata (wdata), .gnt (gnt), .rvalid (rvalid),
      .rdata (rdata), .ram_en (ram_en), .ram_we (ram_we),
      .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
   );

   map_port_arbiter #(.N_REQ(4), .RAM_LATENCY(3)) u_dut3 (
      .vga_pix_clk (vga_pix_clk), .rst (rst), .req (req), .we (we),
      .addr (addr), .wdata (wdata), .gnt (gnt3), .rvalid (rvalid3),
      .rdata (rdata3), .ram_en (ram_en3), .ram_we (ram_we3),
      .ram_addr (ram_addr3), .ram_wdata (ram_wdata3), .ram_rdata (ram_rdata3)
   );

   initial vga_pix_clk = 1'b0;
   always #5 vga_pix_clk = ~vga_pix_clk;

   // Initial map contents: tile 35 holds 2, everything else a simple pattern.
   function automatic logic [3:0] mem_init(input int a);
      if (a == 35) return 4'd2;
      return 4'(a % 13);
   endfunction

   // Requester index expected to win on cycle k of the saturation test.
   function automatic int exp_idx(input int k);
`ifdef MAP_ARB_RENDER_PRIO_EN
      return (k >= 0) ? 0 : 0;
`else
      return k % 4;
`endif
   endfunction

   // Map RAM model: written only through the latency-1 instance's port (both
   // instances issue identical accesses); each instance has its own read delay.
   logic [3:0] mem [0:2047];
   logic [3:0] rd3 [0:2];
   int         wr_count;

   always @(posedge vga_pix_clk) begin
      if (rst) begin
         for (int i = 0; i < 2048; i++) mem[i] <= mem_init(i);
         wr_count <= 0;
      end else if (ram_en && ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wr_count      <= wr_count + 1;
      end
      ram_rdata <= ram_en ? mem[ram_addr] : 4'd0;
      rd3[0]    <= ram_en3 ? mem[ram_addr3] : 4'd0;
      rd3[1]    <= rd3[0];
      rd3[2]    <= rd3[1];
   end
   assign ram_rdata3 = rd3[2];

   // Protocol monitor: a request may only be withdrawn after it was granted.
   logic [3:0] prev_req, prev_gnt;
   logic       prev_rst;
   always @(negedge vga_pix_clk) begin
      if (proto_en && !rst && prev_rst === 1'b0) begin
         for (int i = 0; i < 4; i++) begin
            assert (!(prev_req[i] && !prev_gnt[i] && !req[i]))
               else $error("requester %0d withdrew req before its grant", i);
         end
      end
      prev_req <= req;
      prev_gnt <= gnt;
      prev_rst <= rst;
   end

   task automatic step();
      @(posedge vga_pix_clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; we = '0; addr = '0; wdata = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_pix_clk);
         n_checks++;
         if (gnt !== 4'b0000 || gnt3 !== 4'b0000) begin
            n_errors++; $display("FAIL reset_gnt: got %b/%b want 0000", gnt, gnt3);
         end
         n_checks++;
         if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_we3 !== 1'b0) begin
            n_errors++; $display("FAIL reset_ram: en=%b we=%b we3=%b want 0", ram_en, ram_we, ram_we3);
         end
         n_checks++;
         if (rvalid !== 4'b0000 || rdata !== 4'd0) begin
            n_errors++; $display("FAIL reset_ret: rvalid=%b rdata=%h want 0/0", rvalid, rdata);
         end
         step();
      end
      rst = 1'b0; req = 4'b0000;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_r;
      for (int i = 0; i < 4; i++) begin
         addr[i]  = 11'(i * 10 + 1);
         wdata[i] = 4'(i + 3);
      end
      we = '0;
`ifdef MAP_ARB_RENDER_PRIO_EN
      proto_en = 1'b0;
`endif
      for (int k = 0; k < 11; k++) begin
`ifdef MAP_ARB_RENDER_PRIO_EN
         req = (k < 8) ? 4'b1111 : 4'b0000;
`else
         req = (k <= 4) ? 4'b1111 : ((k >= 8) ? 4'b0000 : 4'(4'b1111 << (k - 4)));
`endif
         @(negedge vga_pix_clk);
         if (k < 8) begin
            n_checks++;
            if (gnt !== 4'(1 << exp_idx(k)) || gnt3 !== 4'(1 << exp_idx(k))) begin
               n_errors++; $display("FAIL rot_gnt k=%0d: got %b/%b want %b", k, gnt, gnt3, 4'(1 << exp_idx(k)));
            end
            n_checks++;
            if (ram_en !== 1'b1 || ram_addr !== 11'(exp_idx(k) * 10 + 1) || ram_wdata3 !== 4'(exp_idx(k) + 3)) begin
               n_errors++; $display("FAIL rot_port k=%0d: en=%b addr=%0d wd=%h want 1/%0d/%h", k, ram_en, ram_addr, ram_wdata3, exp_idx(k) * 10 + 1, exp_idx(k) + 3);
            end
         end
         exp_r = (k >= 1 && k <= 8) ? 4'(1 << exp_idx(k - 1)) : 4'b0000;
         n_checks++;
         if (rvalid !== exp_r || rdata !== ((k >= 1 && k <= 8) ? mem_init(exp_idx(k - 1) * 10 + 1) : 4'd0)) begin
            n_errors++; $display("FAIL rot_ret1 k=%0d: rvalid=%b rdata=%h want %b", k, rvalid, rdata, exp_r);
         end
         exp_r = (k >= 3) ? 4'(1 << exp_idx(k - 3)) : 4'b0000;
         n_checks++;
         if (rvalid3 !== exp_r || rdata3 !== ((k >= 3) ? mem_init(exp_idx(k - 3) * 10 + 1) : 4'd0)) begin
            n_errors++; $display("FAIL rot_ret3 k=%0d: rvalid=%b rdata=%h want %b", k, rvalid3, rdata3, exp_r);
         end
         step();
      end
      proto_en = 1'b1;
   endtask

   task automatic test_single_read();
      req = 4'b0010; we = '0; addr[1] = 11'd35;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt !== 4'b0010 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'd35) begin
         n_errors++; $display("FAIL single_gnt: gnt=%b en=%b we=%b addr=%0d want 0010/1/0/35", gnt, ram_en, ram_we, ram_addr);
      end
      step();
      req = 4'b0000;
      @(negedge vga_pix_clk);
      n_checks++;
      if (rvalid !== 4'b0010 || rdata !== 4'd2) begin
         n_errors++; $display("FAIL single_ret: rvalid=%b rdata=%h want 0010/2", rvalid, rdata);
      end
      step();
   endtask

   task automatic test_write_read();
      req = 4'b0100; we = 4'b0100; addr[2] = 11'd100; wdata[2] = 4'd0;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt !== 4'b0100 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 11'd100 || ram_wdata !== 4'd0) begin
         n_errors++; $display("FAIL wr_port: gnt=%b en=%b we=%b addr=%0d wd=%h want 0100/1/1/100/0", gnt, ram_en, ram_we, ram_addr, ram_wdata);
      end
      step();
      we = 4'b0000;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt !== 4'b0100 || ram_we !== 1'b0 || rvalid !== 4'b0000) begin
         n_errors++; $display("FAIL wr_no_rvalid: gnt=%b we=%b rvalid=%b want 0100/0/0000", gnt, ram_we, rvalid);
      end
      step();
      req = 4'b0000;
      @(negedge vga_pix_clk);
      n_checks++;
      if (rvalid !== 4'b0100 || rdata !== 4'd0) begin
         n_errors++; $display("FAIL wr_readback: rvalid=%b rdata=%h want 0100/0", rvalid, rdata);
      end
      step();
   endtask

   task automatic test_out_of_range();
      int wr_before;
      wr_before = wr_count;
      req = 4'b1000; we = 4'b0000; addr[3] = 11'd1152; wdata[3] = 4'd5;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt !== 4'b1000 || ram_en !== 1'b0 || ram_addr !== 11'd0) begin
         n_errors++; $display("FAIL oob_rd_port: gnt=%b en=%b addr=%0d want 1000/0/0", gnt, ram_en, ram_addr);
      end
      step();
      we = 4'b1000; addr[3] = 11'd2047;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt !== 4'b1000 || ram_en !== 1'b0 || ram_we !== 1'b0 || ram_wdata !== 4'd0) begin
         n_errors++; $display("FAIL oob_wr_port: gnt=%b en=%b we=%b wd=%h want 1000/0/0/0", gnt, ram_en, ram_we, ram_wdata);
      end
      n_checks++;
      if (rvalid !== 4'b1000 || rdata !== 4'hF) begin
         n_errors++; $display("FAIL oob_rd_wall: rvalid=%b rdata=%h want 1000/f", rvalid, rdata);
      end
      step();
      req = 4'b0000; we = 4'b0000;
      @(negedge vga_pix_clk);
      n_checks++;
      if (rvalid !== 4'b0000 || rdata !== 4'd0) begin
         n_errors++; $display("FAIL oob_wr_no_rvalid: rvalid=%b rdata=%h want 0000/0", rvalid, rdata);
      end
      n_checks++;
      if (wr_count !== wr_before || mem[2047] !== mem_init(2047)) begin
         n_errors++; $display("FAIL oob_wr_dropped: writes=%0d mem=%h want %0d/%h", wr_count, mem[2047], wr_before, mem_init(2047));
      end
      step();
      @(negedge vga_pix_clk);
      n_checks++;
      if (rvalid3 !== 4'b1000 || rdata3 !== 4'hF) begin
         n_errors++; $display("FAIL oob_rd_wall_lat3: rvalid=%b rdata=%h want 1000/f", rvalid3, rdata3);
      end
      step();
   endtask

   task automatic test_reset_midflight();
      req = 4'b0010; we = 4'b0000; addr[1] = 11'd35;
      @(negedge vga_pix_clk);
      n_checks++;
      if (gnt3 !== 4'b0010) begin
         n_errors++; $display("FAIL mid_pre_gnt: got %b want 0010", gnt3);
      end
      step();
      req = 4'b0000; rst = 1'b1;
      @(negedge vga_pix_clk);
      n_checks++;
      if (rvalid !== 4'b0000 || rvalid3 !== 4'b0000) begin
         n_errors++; $display("FAIL mid_async_flush: rvalid=%b rvalid3=%b want 0000", rvalid, rvalid3);
      end
      step();
      req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_pix_clk);
         n_checks++;
         if (gnt !== 4'b0000 || gnt3 !== 4'b0000 || ram_en !== 1'b0 || ram_en3 !== 1'b0 || rvalid3 !== 4'b0000) begin
            n_errors++; $display("FAIL mid_in_reset c=%0d: gnt=%b/%b en=%b/%b rvalid3=%b want 0", c, gnt, gnt3, ram_en, ram_en3, rvalid3);
         end
         step();
      end
      rst = 1'b0; req = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         @(negedge vga_pix_clk);
         n_checks++;
         if (rvalid !== 4'b0000 || rvalid3 !== 4'b0000) begin
            n_errors++; $display("FAIL mid_no_late_rvalid c=%0d: rvalid=%b rvalid3=%b want 0000", c, rvalid, rvalid3);
         end
         step();
      end
      // From ptr=0, requesters 1..3 win in index order.
      for (int c = 0; c < 3; c++) begin
         req = 4'(4'b1110 << c);
         @(negedge vga_pix_clk);
         n_checks++;
         if (gnt !== 4'(4'b0010 << c)) begin
            n_errors++; $display("FAIL mid_ptr_reset c=%0d: gnt=%b want %b", c, gnt, 4'(4'b0010 << c));
         end
         step();
      end
      req = 4'b0000;
      repeat (4) step();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      proto_en = 1'b1;
      test_reset();
      test_rotation();
      test_single_read();
      test_write_read();
      test_out_of_range();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
